// File: rtl/leddot_pkg.sv
// Shared constants and types for the 8x8 LED dot-matrix scan controller.
package leddot_pkg;

  localparam logic [15:0] LEDDOT_ROW_BASE  = 16'hf010;
  localparam logic [15:0] LEDDOT_CTRL_ADDR = 16'hf030;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_EN_BIT     = 1;
  localparam int CTRL_DUTY_LSB   = 2;
  localparam int CTRL_DUTY_MSB   = 5;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  typedef logic [7:0] row_t;
  typedef row_t [7:0] frame_t;

endpackage

// File: rtl/leddot_framebuf.sv
// Double-buffered frame store: CPU writes land in back, front is refreshed
// from back only at a frame wrap while a commit is pending.
module leddot_framebuf
  import leddot_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_conf_wr,
  input  logic [15:0] i_conf_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_wrap,
  output logic        o_ctrl_wr,
  output logic [63:0] o_front,
  output logic        o_swap_pending
);

  logic [15:0] w_row_off;
  logic        w_row_wr;
  logic [2:0]  w_row_idx;
  logic        w_ctrl_wr;
  logic        w_swap;

  frame_t r_front;
  frame_t r_back;
  logic   r_pending;

  assign w_row_off = i_conf_addr - LEDDOT_ROW_BASE;
  assign w_row_wr  = i_conf_wr && (w_row_off[1:0] == 2'b00) && (w_row_off < 16'd32);
  assign w_row_idx = w_row_off[4:2];
  assign w_ctrl_wr = i_conf_wr && (i_conf_addr == LEDDOT_CTRL_ADDR);
  assign w_swap    = i_wrap && r_pending;

  // Swap copies the pre-edge back contents, so a row write in the same
  // cycle only reaches back; clearing pending beats a coincident commit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_front   <= '0;
      r_back    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_row_wr) begin
        r_back[w_row_idx] <= i_wdata;
      end
      if (w_swap) begin
        r_front   <= r_back;
        r_pending <= 1'b0;
      end else if (w_ctrl_wr && i_wdata[CTRL_COMMIT_BIT]) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_ctrl_wr      = w_ctrl_wr;
  assign o_front        = r_front;
  assign o_swap_pending = r_pending;

endmodule

// File: rtl/leddot_scan_ctrl.sv
// Row-multiplexed scan of the 8x8 LED matrix with a blanking gap per row slot.
// Optional macro LEDDOT_DIM_EN adds a CTRL[5:2] duty control for dimming.
module leddot_scan_ctrl
  import leddot_pkg::*;
#(
  parameter int CLK_DIV   = 5000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        conf_wr,
  input  logic [31:0] conf_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [7:0]  led_dotr,
  output logic [7:0]  led_dotc,
  output logic        frame_sync,
  output logic        swap_pending,
  output logic [1:0]  o_dbg_state
);

  localparam int CW        = $clog2(CLK_DIV);
  localparam int DW        = CW + 5;
  localparam int DRIVE_CYC = CLK_DIV - BLANK_CYC;

  localparam logic [CW-1:0] LP_BLANK      = CW'(BLANK_CYC);
  localparam logic [CW-1:0] LP_BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] LP_SLOT_LAST  = CW'(CLK_DIV - 1);

  logic [1:0]    r_state;
  logic [2:0]    r_row_idx;
  logic [CW-1:0] r_cnt;
  logic          r_enable;
  logic [7:0]    r_dotr;
  logic [7:0]    r_dotc;
  logic          r_frame_sync;

  logic          w_ctrl_wr;
  logic          w_en_next;
  logic          w_wrap;
  logic          w_lit;
  logic [63:0]   w_front;
  logic [7:0]    w_front_row;
  logic          w_unused;

  leddot_framebuf u_framebuf (
    .clk            (clk),
    .resetn         (resetn),
    .i_conf_wr      (conf_wr),
    .i_conf_addr    (conf_addr[15:0]),
    .i_wdata        (cpu_data_wdata[7:0]),
    .i_wrap         (w_wrap),
    .o_ctrl_wr      (w_ctrl_wr),
    .o_front        (w_front),
    .o_swap_pending (swap_pending)
  );

  // A disabling CTRL write acts in the same edge it is sampled, so the
  // outputs blank on the very next cycle and any coincident wrap is dropped.
  assign w_en_next   = w_ctrl_wr ? cpu_data_wdata[CTRL_EN_BIT] : r_enable;
  assign w_wrap      = w_en_next && (r_state == ST_DRIVE) &&
                       (r_cnt == LP_SLOT_LAST) && (r_row_idx == 3'd7);
  assign w_front_row = w_front[{r_row_idx, 3'b000} +: 8];

`ifdef LEDDOT_DIM_EN
  logic [3:0]    r_duty;
  logic [DW-1:0] w_lit_prod;
  logic [DW-1:0] w_lit_len;
  logic [CW-1:0] w_drive_cnt;

  assign w_lit_prod  = (DW'({1'b0, r_duty}) + DW'(1)) * DW'(DRIVE_CYC);
  assign w_lit_len   = w_lit_prod >> 4;
  assign w_drive_cnt = r_cnt - LP_BLANK;
  assign w_lit       = ({5'b00000, w_drive_cnt} < w_lit_len);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_duty <= 4'hF;
    end else if (w_ctrl_wr) begin
      r_duty <= cpu_data_wdata[CTRL_DUTY_MSB:CTRL_DUTY_LSB];
    end
  end
`else
  assign w_lit = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_OFF;
      r_row_idx    <= 3'd0;
      r_cnt        <= '0;
      r_enable     <= 1'b0;
      r_dotr       <= 8'h00;
      r_dotc       <= 8'hFF;
      r_frame_sync <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= cpu_data_wdata[CTRL_EN_BIT];
      end
      r_frame_sync <= w_wrap;

      if (!w_en_next) begin
        r_state   <= ST_OFF;
        r_row_idx <= 3'd0;
        r_cnt     <= '0;
      end else begin
        case (r_state)
          ST_OFF: begin
            r_state   <= ST_BLANK;
            r_row_idx <= 3'd0;
            r_cnt     <= '0;
          end
          ST_BLANK: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LP_BLANK_LAST) begin
              r_state <= ST_DRIVE;
            end
          end
          ST_DRIVE: begin
            if (r_cnt == LP_SLOT_LAST) begin
              r_cnt     <= '0;
              r_row_idx <= r_row_idx + 3'd1;
              r_state   <= ST_BLANK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state   <= ST_OFF;
            r_row_idx <= 3'd0;
            r_cnt     <= '0;
          end
        endcase
      end

      if (w_en_next && (r_state == ST_DRIVE) && w_lit) begin
        r_dotr <= 8'b1 << r_row_idx;
        r_dotc <= ~w_front_row;
      end else begin
        r_dotr <= 8'h00;
        r_dotc <= 8'hFF;
      end
    end
  end

  assign led_dotr    = r_dotr;
  assign led_dotc    = r_dotc;
  assign frame_sync  = r_frame_sync;
  assign o_dbg_state = r_state;
  assign w_unused    = ^{conf_addr[31:16], cpu_data_wdata[31:8]};

endmodule

// File: tb/tb_leddot_scan_ctrl.sv
// Bench for leddot_scan_ctrl (CLK_DIV=8, BLANK_CYC=2) against a scan-time model.
module tb_leddot_scan_ctrl;

  logic        clk;
  logic        resetn;
  logic        conf_wr;
  logic [31:0] conf_addr;
  logic [31:0] cpu_data_wdata;
  logic [7:0]  led_dotr;
  logic [7:0]  led_dotc;
  logic        frame_sync;
  logic        swap_pending;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  leddot_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .conf_wr        (conf_wr),
    .conf_addr      (conf_addr),
    .cpu_data_wdata (cpu_data_wdata),
    .led_dotr       (led_dotr),
    .led_dotc       (led_dotc),
    .frame_sync     (frame_sync),
    .swap_pending   (swap_pending),
    .o_dbg_state    (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: m_s is the scan time (cycles since the scan started) of the
  // design's state during the current cycle; outputs show it one edge later.
  bit         m_run;
  int         m_s;
  logic       m_en;
  logic       m_pend;
  logic [3:0] m_duty;
  logic [7:0] m_front [8];
  logic [7:0] m_back  [8];
  logic [7:0] exp_dotr;
  logic [7:0] exp_dotc;
  logic       exp_fs;

  function automatic int lit_len();
`ifdef LEDDOT_DIM_EN
    return ((int'(m_duty) + 1) * 6) >> 4;
`else
    return 6;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_s = 0; m_en = 0; m_pend = 0; m_duty = 4'hF;
    for (int i = 0; i < 8; i++) begin
      m_front[i] = 8'h00;
      m_back[i]  = 8'h00;
    end
  endtask

  task automatic model_edge(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic ctrl, en_next, run, swap;
    int row, p;
    ctrl    = wr && (addr[15:0] == 16'hf030);
    en_next = ctrl ? data[1] : m_en;
    run     = m_run && en_next;
    exp_dotr = 8'h00; exp_dotc = 8'hFF; exp_fs = 1'b0;
    if (run) begin
      row = (m_s / 8) % 8;
      p   = m_s % 8;
      if (p >= 2 && (p - 2) < lit_len()) begin
        exp_dotr = 8'(1 << row);
        exp_dotc = ~m_front[row];
      end
      exp_fs = ((m_s % 64) == 63);
    end
    swap = exp_fs && m_pend;
    if (swap) begin
      for (int i = 0; i < 8; i++) m_front[i] = m_back[i];
      m_pend = 0;
    end else if (ctrl && data[0]) begin
      m_pend = 1;
    end
    for (int i = 0; i < 8; i++)
      if (wr && addr[15:0] == 16'hf010 + 16'(4 * i)) m_back[i] = data[7:0];
    if (ctrl) begin
      m_en   = data[1];
      m_duty = data[5:2];
    end
    if (en_next) begin
      if (m_run) m_s++;
      else begin m_run = 1; m_s = 0; end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    conf_wr = wr; conf_addr = addr; cpu_data_wdata = data;
    @(posedge clk);
    model_edge(wr, addr, data);
    #1;
    conf_wr = 1'b0;
    chk("dotr", led_dotr, exp_dotr);
    chk("dotc", led_dotc, exp_dotc);
    chk("frame_sync", {7'd0, frame_sync}, {7'd0, exp_fs});
    chk("swap_pending", {7'd0, swap_pending}, {7'd0, m_pend});
  endtask

  task automatic wr_row(input int i, input logic [7:0] v);
    step(1'b1, 32'h0000f010 + 32'(4 * i), {24'd0, v});
  endtask

  task automatic wr_ctrl(input logic [7:0] v);
    step(1'b1, 32'h0000f030, {24'd0, v});
  endtask

  task automatic run_to(input int pos);
    int n;
    n = 0;
    while (!(m_run && (m_s % 64) == pos) && n < 200) begin
      step(1'b0, 32'd0, 32'd0);
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL run_to: observed=timeout expected=scan pos %0d", pos);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; conf_wr = 1'b0; conf_addr = '0; cpu_data_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int cnt, first;
    logic [7:0] rec_r [8];
    logic [7:0] rec_c [8];

    do_reset();
    #1;
    chk("rst_dotr", led_dotr, 8'h00);
    chk("rst_dotc", led_dotc, 8'hFF);
    chk("rst_fs", {7'd0, frame_sync}, 8'h00);
    chk("rst_pend", {7'd0, swap_pending}, 8'h00);

    // Enable, write row 0, commit; row 0 appears after the first wrap
    wr_ctrl(8'h02);
    wr_row(0, 8'h81);
    wr_ctrl(8'h03);
    run_to(63);
    step(1'b0, 32'd0, 32'd0);
    chk("wrap_fs", {7'd0, frame_sync}, 8'h01);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'd0, 32'd0);
      rec_r[i] = led_dotr;
      rec_c[i] = led_dotc;
      if (led_dotr == 8'h01 && led_dotc == 8'h7E) cnt++;
    end
    chk("row0_blank0", rec_r[0], 8'h00);
    chk("row0_blank1", rec_c[1], 8'hFF);
    chk("row0_lit_cycles", 8'(cnt), 8'd6);

    // One frame_sync per 64-cycle frame
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 32'd0, 32'd0);
      if (frame_sync) cnt++;
    end
    chk("fs_per_frame", 8'(cnt), 8'd1);

    // Row 3 write stays hidden until commit and wrap
    wr_row(3, 8'hFF);
    chk("pend_no_commit", {7'd0, swap_pending}, 8'h00);
    run_to(26);
    step(1'b0, 32'd0, 32'd0);
    chk("row3_old", led_dotc, 8'hFF);
    wr_ctrl(8'h03);
    chk("pend_set", {7'd0, swap_pending}, 8'h01);
    run_to(63);
    step(1'b0, 32'd0, 32'd0);
    chk("pend_cleared", {7'd0, swap_pending}, 8'h00);
    run_to(26);
    step(1'b0, 32'd0, 32'd0);
    chk("row3_new_r", led_dotr, 8'h08);
    chk("row3_new_c", led_dotc, 8'h00);

    // Commit in the wrap cycle is deferred; row write in swap cycle goes to back only
    wr_row(5, 8'h0F);
    run_to(63);
    wr_ctrl(8'h03);
    chk("commit_at_wrap_pend", {7'd0, swap_pending}, 8'h01);
    run_to(43);
    step(1'b0, 32'd0, 32'd0);
    chk("row5_deferred", led_dotc, 8'hFF);
    run_to(63);
    wr_row(5, 8'hAA);
    chk("swap_cycle_pend", {7'd0, swap_pending}, 8'h00);
    run_to(43);
    step(1'b0, 32'd0, 32'd0);
    chk("row5_old_back", led_dotc, 8'hF0);
    wr_ctrl(8'h03);
    run_to(63);
    step(1'b0, 32'd0, 32'd0);
    run_to(43);
    step(1'b0, 32'd0, 32'd0);
    chk("row5_new", led_dotc, 8'h55);

    // Disable during row 4 drive, then re-enable restarts at row 0
    run_to(36);
    wr_ctrl(8'h01);
    chk("dis_dotr", led_dotr, 8'h00);
    chk("dis_dotc", led_dotc, 8'hFF);
    chk("dis_pend_kept", {7'd0, swap_pending}, 8'h01);
    repeat (5) step(1'b0, 32'd0, 32'd0);
    wr_ctrl(8'h02);
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 32'd0, 32'd0);
      if (first == 0 && led_dotr != 8'h00) begin
        first = i;
        chk("reen_row0", led_dotr, 8'h01);
      end
    end
    chk("reen_latency", 8'(first), 8'd3);

    // Asynchronous reset in the middle of a drive slot
    run_to(20);
    step(1'b0, 32'd0, 32'd0);
    chk("pre_rst_drive", led_dotr, 8'h04);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_dotr", led_dotr, 8'h00);
    chk("arst_dotc", led_dotc, 8'hFF);
    chk("arst_pend", {7'd0, swap_pending}, 8'h00);
    chk("arst_fs", {7'd0, frame_sync}, 8'h00);
    do_reset();

    // Randomized writes against the model
    wr_ctrl(8'h02);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        int sel;
        logic [31:0] d;
        sel = $urandom_range(0, 9);
        d   = $urandom;
        if (sel < 6) begin
          step(1'b1, {16'($urandom), 16'hf010 + 16'(4 * $urandom_range(0, 7))}, d);
        end else if (sel < 9) begin
          d[1] = ($urandom_range(0, 9) != 0);
          step(1'b1, {16'($urandom), 16'hf030}, d);
        end else begin
          step(1'b1, {16'($urandom), 16'hf011 + 16'($urandom_range(0, 2))}, d);
        end
      end else begin
        step(1'b0, 32'd0, 32'd0);
      end
    end

    // Duty 2: 1 lit cycle per slot with dimming, else the full 6
    do_reset();
    for (int i = 0; i < 8; i++) wr_row(i, 8'($urandom_range(1, 255)));
    wr_ctrl(8'h0B);
    run_to(63);
    step(1'b0, 32'd0, 32'd0);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 32'd0, 32'd0);
      if (led_dotr != 8'h00) cnt++;
    end
`ifdef LEDDOT_DIM_EN
    chk("dim_lit_per_frame", 8'(cnt), 8'd8);
`else
    chk("full_lit_per_frame", 8'(cnt), 8'd48);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
